pong_button_ctrl: RTL and testbench
===================================

// Module: pong_button_ctrl
// PURPOSE
//  Input stage for the Pong datapath. Conditions 5 raw push-buttons (2-FF sync + per-bit debounce) and emits action
//  transactions on mAccion/bandera. The bar/ball engine consumes them and updates bar positions on posedge bandera.
//  mAccion is held stable around every bandera edge, so bandera is safe to use as an edge/clock in the consumer.
// PARAMETERS
//  DEBOUNCE_CYCLES  250000   consecutive stable cycles needed to accept a level change (10 ms @ 25 MHz)
//  PULSE_CYCLES     4        cycles bandera stays high per transaction (>=1)
//  REPEAT_DELAY     5000000  held-button delay before first auto-repeat (AUTO_REPEAT_EN only)
//  REPEAT_PERIOD    2500000  auto-repeat interval after first repeat (AUTO_REPEAT_EN only)
// PORTS
//  Clock      in   1  25 MHz system clock
//  Reset      in   1  asynchronous, active-high
//  iBtn       in   5  raw buttons, active-high, async; [0]start [1]bar1 left [2]bar1 right [3]bar0 right [4]bar0 left
//  mAccion    out  5  action mask for current transaction, same bit map as iBtn
//  bandera    out  1  transaction strobe
//  oBtnLevel  out  5  debounced button levels
// BEHAVIOUR
//  Reset (async): mAccion=0, bandera=0, oBtnLevel=0, pending=0, all counters=0, FSM=IDLE; takes effect immediately.
//  Sync: 2 flops per bit, reset to 0. Debounce per bit: counter clears while synced==stable.
//   Counter increments while synced!=stable. At DEBOUNCE_CYCLES-1, stable<=synced and the counter clears.
//   Counter width = $clog2(DEBOUNCE_CYCLES).
//  Event: rising edge of stable bit i sets pending[i] on the next edge. Release generates no event.
//   A second event on a bit already pending is merged (single bit, no count).
//  FSM (2-bit state) IDLE -> SETUP -> STROBE -> GAP -> IDLE:
//   IDLE: if pending!=0, go to SETUP. On that edge: mAccion<=pending, and the captured bits clear in pending.
//    Events arriving on that same edge stay pending.
//   SETUP: 1 cycle, bandera=0, mAccion valid (setup before the strobe edge).
//   STROBE: bandera=1 for exactly PULSE_CYCLES cycles; mAccion held.
//   GAP: 1 cycle, bandera=0, mAccion held (hold after the falling edge). Then IDLE with mAccion<=0.
//  Latency: pending set at edge t -> mAccion valid after edge t+1 -> bandera rises at edge t+2.
//  Transaction length: PULSE_CYCLES+2 cycles, plus 1 IDLE cycle minimum between transactions.
//  mAccion never changes while bandera=1 or during SETUP/GAP. Events during a transaction wait in pending.
//  Conflicting bits (e.g. [1] and [2] together) pass through unchanged; the consumer applies priority.
//  A button held through reset release yields one event DEBOUNCE_CYCLES+2 cycles after release, since stable resets to 0.
// CONFIGURATION
//  AUTO_REPEAT_EN defined: bits [4:1] only. While stable high, a per-bit repeat counter runs.
//   It sets pending at REPEAT_DELAY cycles after the press edge, then every REPEAT_PERIOD cycles.
//   The counter clears on release or reset. Bit [0] never repeats.
//  AUTO_REPEAT_EN undefined: repeat counters are absent; one event per debounced press only.
// STRUCTURE
//  pong_pkg: button index constants (BTN_START=0, BAR1_LEFT=1, BAR1_RIGHT=2, BAR0_RIGHT=3, BAR0_LEFT=4).
//   Also FSM state encodings (IDLE, SETUP, STROBE, GAP) and NUM_BTN=5.
//  Sub-module btn_debounce (sync + debounce + rise-edge pulse, one bit) is instanced 5x via generate.
//   Pending register, repeat counters and FSM are in this module.
// TESTING (bench params: DEBOUNCE_CYCLES=4, PULSE_CYCLES=2, REPEAT_DELAY=20, REPEAT_PERIOD=8)
//  1 Clean press iBtn[1] high 10 cycles -> one transaction: mAccion=5'b00010, bandera high 2 cycles.
//    Latency must match the numbers above; mAccion=0 after GAP.
//  2 iBtn[3] toggles every 2 cycles for 12 cycles, then held high -> exactly one transaction, mAccion=5'b01000.
//  3 iBtn[1] and iBtn[4] rise in the same cycle -> single transaction, mAccion=5'b10010.
//  4 iBtn[2] debounced during STROBE of a [1] transaction -> mAccion stays 5'b00010 while bandera=1.
//    Second transaction 5'b00100 starts after GAP + 1 IDLE cycle.
//  5 Reset pulse mid-STROBE -> bandera=0, mAccion=0 without waiting for a clock edge.
//    Button held across reset -> one event after re-debounce.
//  6 AUTO_REPEAT_EN: hold iBtn[4] 60 cycles -> transactions at press event, +20, +28, +36, +44, +52 (cycles).
//    Without macro -> one transaction only.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared constants and types for the Pong button input stage.
package pong_pkg;

  localparam int NUM_BTN    = 5;

  localparam int BTN_START  = 0;
  localparam int BAR1_LEFT  = 1;
  localparam int BAR1_RIGHT = 2;
  localparam int BAR0_RIGHT = 3;
  localparam int BAR0_LEFT  = 4;

  typedef logic [NUM_BTN-1:0] btn_mask_t;

  // Only the bar buttons are allowed to auto-repeat; start must stay a one-shot.
  localparam btn_mask_t REPEAT_MASK = btn_mask_t'((1 << BAR1_LEFT) | (1 << BAR1_RIGHT) |
                                                  (1 << BAR0_RIGHT) | (1 << BAR0_LEFT));

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    GAP    = 2'd3
  } ctrl_state_t;

  // Width of a counter that must hold values 0 .. n-1 (never narrower than 1 bit).
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: 2-flop synchronizer, stability debounce and a one-cycle
// pulse on the rising edge of the debounced level.
module btn_debounce
  import pong_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic Clock,
  input  logic Reset,
  input  logic btn_raw,
  output logic level,
  output logic rise
);

  localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_0;
  logic             sync_1;
  logic             level_q;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sync_0  <= 1'b0;
      sync_1  <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_0  <= btn_raw;
      sync_1  <= sync_0;
      level_q <= level;
      // Any sample that agrees with the accepted level restarts the stability window.
      if (sync_1 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_1;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/pong_button_ctrl.sv
// Pong input stage: debounces the five buttons and emits mAccion/bandera transactions.
// Optional build macro AUTO_REPEAT_EN adds held-button auto-repeat on the bar buttons.
//
// state  | meaning
// IDLE   | mAccion=0, waiting for any pending action
// SETUP  | mAccion valid, bandera low (setup before the strobe edge)
// STROBE | bandera high for PULSE_CYCLES cycles, mAccion held
// GAP    | bandera low, mAccion held (hold after the falling edge)
module pong_button_ctrl
  import pong_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int PULSE_CYCLES    = 4,
  parameter int REPEAT_DELAY    = 5000000,
  parameter int REPEAT_PERIOD   = 2500000
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [NUM_BTN-1:0] iBtn,
  output logic [NUM_BTN-1:0] mAccion,
  output logic               bandera,
  output logic [NUM_BTN-1:0] oBtnLevel
);

  localparam int               PULSE_W    = cnt_width(PULSE_CYCLES);
  localparam logic [PULSE_W-1:0] PULSE_LOAD = PULSE_W'(PULSE_CYCLES - 1);

  btn_mask_t        btn_rise;
  btn_mask_t        rpt_fire;
  btn_mask_t        btn_event;
  btn_mask_t        pending;
  btn_mask_t        capture;
  ctrl_state_t      state;
  logic [PULSE_W-1:0] pulse_cnt;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .Clock  (Clock),
      .Reset  (Reset),
      .btn_raw(iBtn[g]),
      .level  (oBtnLevel[g]),
      .rise   (btn_rise[g])
    );
  end

`ifdef AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = cnt_width(RPT_MAX);
  localparam logic [RPT_W-1:0] RPT_DELAY_LOAD  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_PERIOD_LOAD = RPT_W'(REPEAT_PERIOD - 1);

  for (genvar r = 0; r < NUM_BTN; r++) begin : g_rpt
    if (REPEAT_MASK[r]) begin : g_on
      logic [RPT_W-1:0] rpt_cnt;

      // Loaded on the press event, so the first repeat lands REPEAT_DELAY edges later.
      always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
          rpt_cnt <= '0;
        end else if (btn_rise[r]) begin
          rpt_cnt <= RPT_DELAY_LOAD;
        end else if (!oBtnLevel[r]) begin
          rpt_cnt <= '0;
        end else if (rpt_cnt == '0) begin
          rpt_cnt <= RPT_PERIOD_LOAD;
        end else begin
          rpt_cnt <= rpt_cnt - 1'b1;
        end
      end

      assign rpt_fire[r] = oBtnLevel[r] & ~btn_rise[r] & (rpt_cnt == '0);
    end else begin : g_off
      assign rpt_fire[r] = 1'b0;
    end
  end
`else
  logic unused_rpt_cfg;
  assign unused_rpt_cfg = (REPEAT_DELAY != 0) | (REPEAT_PERIOD != 0) | (|REPEAT_MASK);
  assign rpt_fire       = '0;
`endif

  assign btn_event = btn_rise | rpt_fire;

  // Bits handed to the FSM leave pending; events landing on the same edge stay.
  assign capture = (state == IDLE) ? pending : '0;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~capture) | btn_event;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      mAccion   <= '0;
      bandera   <= 1'b0;
      pulse_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pending != '0) begin
            state   <= SETUP;
            mAccion <= pending;
          end
        end
        SETUP: begin
          state     <= STROBE;
          bandera   <= 1'b1;
          pulse_cnt <= PULSE_LOAD;
        end
        STROBE: begin
          if (pulse_cnt == '0) begin
            state   <= GAP;
            bandera <= 1'b0;
          end else begin
            pulse_cnt <= pulse_cnt - 1'b1;
          end
        end
        GAP: begin
          state   <= IDLE;
          mAccion <= '0;
        end
        default: begin
          state   <= IDLE;
          mAccion <= '0;
          bandera <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pong_button_ctrl.sv
// Self-checking bench for pong_button_ctrl: cycle model of the button rules plus directed cases.
module tb_pong_button_ctrl;

  localparam int DEB = 4;
  localparam int PUL = 2;
  localparam int RD  = 20;
  localparam int RP  = 8;
  localparam int NB  = 5;
`ifdef AUTO_REPEAT_EN
  localparam bit RPT_ON = 1'b1;
`else
  localparam bit RPT_ON = 1'b0;
`endif

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic [NB-1:0] iBtn  = '0;
  logic [NB-1:0] mAccion;
  logic          bandera;
  logic [NB-1:0] oBtnLevel;

  pong_button_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .PULSE_CYCLES   (PUL),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .iBtn     (iBtn),
    .mAccion  (mAccion),
    .bandera  (bandera),
    .oBtnLevel(oBtnLevel)
  );

  always #5 Clock = ~Clock;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got %b, want %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_n(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Raw input seen two edges late; a level is accepted after DEB consecutive disagreeing
  // edges; a press event is posted one edge after acceptance; a transaction occupies
  // PUL+2 cycles after its start edge and the next may start PUL+3 edges later.
  logic [NB-1:0] m_d1, m_d2, m_level, m_level_prev, m_pend, m_mask, m_ev;
  int            m_run [NB];
  int            m_age [NB];
  int            m_edge, m_start;
  bit            m_busy;

  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      m_d1 = '0; m_d2 = '0; m_level = '0; m_level_prev = '0; m_pend = '0; m_mask = '0;
      m_edge = 0; m_start = 0; m_busy = 1'b0;
      for (int i = 0; i < NB; i++) begin m_run[i] = 0; m_age[i] = -1; end
    end else begin
      m_ev = '0;
      for (int i = 0; i < NB; i++) begin
        if (m_level[i] && !m_level_prev[i]) begin
          m_ev[i] = 1'b1;
          m_age[i] = 0;
        end else if (m_level[i] && m_age[i] >= 0) begin
          m_age[i]++;
          if (RPT_ON && i != 0 && m_age[i] >= RD && (m_age[i] - RD) % RP == 0) m_ev[i] = 1'b1;
        end else begin
          m_age[i] = -1;
        end
      end
      m_edge++;
      if ((!m_busy || m_edge - m_start >= PUL + 3) && m_pend != '0) begin
        m_busy  = 1'b1;
        m_start = m_edge;
        m_mask  = m_pend;
        m_pend  = m_ev;
      end else begin
        m_pend = m_pend | m_ev;
      end
      m_level_prev = m_level;
      for (int i = 0; i < NB; i++) begin
        if (m_d2[i] != m_level[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin m_level[i] = m_d2[i]; m_run[i] = 0; end
        end else begin
          m_run[i] = 0;
        end
      end
      m_d2 = m_d1;
      m_d1 = iBtn;
    end
  end

  logic [NB-1:0] e_acc;
  logic          e_band;
  int            e_off;

  always @(negedge Clock) begin
    if (!Reset) begin
      e_acc  = '0;
      e_band = 1'b0;
      if (m_busy) begin
        e_off = m_edge - m_start;
        if (e_off <= PUL + 1) begin
          e_acc  = m_mask;
          e_band = (e_off >= 1) && (e_off <= PUL);
        end
      end
      chk("model_mAccion", mAccion, e_acc);
      chk("model_bandera", {4'b0, bandera}, {4'b0, e_band});
      chk("model_oBtnLevel", oBtnLevel, m_level);
    end
  end

  // ---------------- transaction monitor ----------------
  int            rise_cyc [$];
  logic [NB-1:0] rise_mask[$];
  logic          band_q = 1'b0;

  always @(negedge Clock) begin
    if (Reset) begin
      band_q = 1'b0;
    end else begin
      if (bandera && !band_q) begin
        rise_cyc.push_back(cyc);
        rise_mask.push_back(mAccion);
      end
      band_q = bandera;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge Clock);
    #1;
  endtask

  task automatic idle(input int n);
    iBtn = '0;
    step(n);
  endtask

  task automatic wait_band(input int budget, input string nm);
    int k;
    k = 0;
    while (!bandera && k < budget) begin step(1); k++; end
    chk_n({nm, "_timeout"}, int'(bandera), 1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int base;
    step(3);
    chk("reset_mAccion", mAccion, 5'b00000);
    chk("reset_bandera", {4'b0, bandera}, 5'b00000);
    chk("reset_level", oBtnLevel, 5'b00000);
    Reset = 1'b0;
    step(4);

    // 1: clean press, literal latency
    iBtn[1] = 1'b1;
    step(6);
    chk("t1_level", oBtnLevel, 5'b00010);
    chk("t1_pre_acc", mAccion, 5'b00000);
    step(2);
    chk("t1_setup_acc", mAccion, 5'b00010);
    chk("t1_setup_band", {4'b0, bandera}, 5'b00000);
    step(1);
    chk("t1_strobe0", {4'b0, bandera}, 5'b00001);
    step(1);
    chk("t1_strobe1", {4'b0, bandera}, 5'b00001);
    chk("t1_strobe_acc", mAccion, 5'b00010);
    iBtn[1] = 1'b0;
    step(1);
    chk("t1_gap_band", {4'b0, bandera}, 5'b00000);
    chk("t1_gap_acc", mAccion, 5'b00010);
    step(1);
    chk("t1_idle_acc", mAccion, 5'b00000);
    idle(20);

    // 2: bouncing input then held
    base = rise_cyc.size();
    for (int k = 0; k < 6; k++) begin iBtn[3] = (k % 2 == 0); step(2); end
    iBtn[3] = 1'b1;
    step(15);
    idle(20);
    chk_n("t2_count", rise_cyc.size() - base, 1);
    if (rise_cyc.size() > base) chk("t2_mask", rise_mask[base], 5'b01000);

    // 3: simultaneous presses merge
    base = rise_cyc.size();
    iBtn = 5'b10010;
    step(12);
    idle(20);
    chk_n("t3_count", rise_cyc.size() - base, 1);
    if (rise_cyc.size() > base) chk("t3_mask", rise_mask[base], 5'b10010);

    // 4: second press lands during STROBE
    base = rise_cyc.size();
    iBtn[1] = 1'b1;
    step(3);
    iBtn[2] = 1'b1;
    step(8);
    idle(25);
    chk_n("t4_count", rise_cyc.size() - base, 2);
    if (rise_cyc.size() > base + 1) begin
      chk("t4_mask0", rise_mask[base], 5'b00010);
      chk("t4_mask1", rise_mask[base + 1], 5'b00100);
      chk_n("t4_spacing", rise_cyc[base + 1] - rise_cyc[base], PUL + 3);
    end

    // 5: reset mid-STROBE, button held across it
    iBtn[1] = 1'b1;
    wait_band(30, "t5_band");
    #2 Reset = 1'b1;
    #1;
    chk("t5_async_band", {4'b0, bandera}, 5'b00000);
    chk("t5_async_acc", mAccion, 5'b00000);
    chk("t5_async_level", oBtnLevel, 5'b00000);
    step(2);
    base = rise_cyc.size();
    Reset = 1'b0;
    step(20);
    chk_n("t5_count", rise_cyc.size() - base, 1);
    if (rise_cyc.size() > base) chk("t5_mask", rise_mask[base], 5'b00010);
    idle(40);

    // 6: long hold, auto-repeat timing
    base = rise_cyc.size();
    iBtn[4] = 1'b1;
    step(60);
    idle(30);
    chk_n("t6_count", rise_cyc.size() - base, RPT_ON ? 6 : 1);
    if (RPT_ON && rise_cyc.size() >= base + 6) begin
      chk_n("t6_first_repeat", rise_cyc[base + 1] - rise_cyc[base], RD);
      for (int k = 2; k < 6; k++) chk_n("t6_period", rise_cyc[base + k] - rise_cyc[base + k - 1], RP);
    end

    // random phase, checked by the model every cycle
    for (int n = 0; n < 400; n++) begin
      iBtn = NB'($urandom_range(0, 31));
      step($urandom_range(1, 14));
    end
    idle(40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
